uart_tx_serializer: RTL

- Parametrised UART transmit serializer: the next generation of the team's TX shift-register stage.
- Accepts parallel words over a valid/ready handshake and frames each one internally: start bit, DATA_BITS data LSB-first, optional even/odd parity, 1 or 2 stop bits.
- Contains its own bit-period counter, so the upstream controller no longer sequences load/shift.
- Sits between the TX FIFO/controller and the serial line pin.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_serializer_if.sv | 27 ++
 rtl/uart_baud_counter.sv | 32 +++
 rtl/uart_tx_serializer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART states, parity-mode codes and line constants
// Rev 1.0
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic TX_IDLE = 1'b1;

  // Words are zero-extended to 9 bits; the padding does not change the XOR.
  function automatic logic calc_parity(input logic [8:0] data, input logic [1:0] mode);
    return (mode == PAR_ODD) ? ~(^data) : (^data);
  endfunction

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// uart_tx_serializer_if : word handshake and serial line bundle
// Rev 1.0
// ============================================================================
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           parity_mode;
  logic                 two_stop;
  logic                 tx;
  logic                 busy;

  modport master (
    output in_data, in_valid, parity_mode, two_stop,
    input  in_ready, tx, busy
  );

  modport slave (
    input  in_data, in_valid, parity_mode, two_stop,
    output in_ready, tx, busy
  );
endinterface
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// uart_baud_counter : free-running bit-period counter with bit_done strobe
// Rev 1.0
// ============================================================================
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bit_done
);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      r_count <= '0;
    end else if (r_count == c_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign bit_done = !clear && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// uart_tx_serializer : framed UART transmitter with valid/ready word input
// Rev 1.0
// ============================================================================
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_tx_serializer_if.slave   bus
);
  localparam int              BIDX_W     = $clog2(DATA_BITS + 1);
  localparam logic [BIDX_W-1:0] c_last_bit = BIDX_W'(DATA_BITS - 1);

  uart_state_t            r_state, w_state_next;
  logic [DATA_BITS-1:0]   r_shift, w_shift_next;
  logic [BIDX_W-1:0]      r_bit_idx, w_bit_idx_next;
  logic                   r_stop_idx, w_stop_idx_next;
  logic                   r_par_en, w_par_en_next;
  logic                   r_par_bit, w_par_bit_next;
  logic                   r_two_stop, w_two_stop_next;
  logic                   r_tx, w_tx_next;
  logic                   w_bit_done;
  logic                   w_last_stop;
  logic                   w_in_ready;
  logic                   w_accept;

  uart_baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (r_state == IDLE),
    .bit_done (w_bit_done)
  );

  // Ready on the final stop cycle lets the next frame start with no idle gap.
  assign w_last_stop = (r_state == STOP) && w_bit_done && (!r_two_stop || r_stop_idx);
  assign w_in_ready  = (r_state == IDLE) || w_last_stop;
  assign w_accept    = bus.in_valid && w_in_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_two_stop <= 1'b0;
      r_tx       <= TX_IDLE;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_idx  <= w_bit_idx_next;
      r_stop_idx <= w_stop_idx_next;
      r_par_en   <= w_par_en_next;
      r_par_bit  <= w_par_bit_next;
      r_two_stop <= w_two_stop_next;
      r_tx       <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_idx_next  = r_bit_idx;
    w_stop_idx_next = r_stop_idx;
    w_par_en_next   = r_par_en;
    w_par_bit_next  = r_par_bit;
    w_two_stop_next = r_two_stop;
    w_tx_next       = TX_IDLE;

    case (r_state)
      IDLE: ;
      START: begin
        if (w_bit_done) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
        end
      end
      DATA: begin
        if (w_bit_done) begin
          w_shift_next = r_shift >> 1;
          if (r_bit_idx == c_last_bit) begin
            w_bit_idx_next  = '0;
            w_stop_idx_next = 1'b0;
            w_state_next    = r_par_en ? PARITY : STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_done) begin
          w_state_next    = STOP;
          w_stop_idx_next = 1'b0;
        end
      end
      STOP: begin
        if (w_bit_done) begin
          if (r_two_stop && !r_stop_idx) begin
            w_stop_idx_next = 1'b1;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Capture overrides the end-of-frame return to IDLE.
    if (w_accept) begin
      w_state_next    = START;
      w_shift_next    = bus.in_data;
      w_bit_idx_next  = '0;
      w_stop_idx_next = 1'b0;
      w_par_en_next   = parity_enabled(bus.parity_mode);
      w_par_bit_next  = calc_parity(9'(bus.in_data), bus.parity_mode);
      w_two_stop_next = bus.two_stop;
    end

    case (w_state_next)
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = w_shift_next[0];
      PARITY:  w_tx_next = w_par_bit_next;
      default: w_tx_next = TX_IDLE;
    endcase
  end

  assign bus.tx       = r_tx;
  assign bus.busy     = (r_state != IDLE);
  assign bus.in_ready = w_in_ready;

endmodule
`default_nettype wire
